// File: rtl/multi_port_latency_memory.sv
// -----------------------------------------------------------------------------
// multi_port_latency_memory
//
// Shared storage macro: one byte-enabled write port and NUM_RD independent
// read ports. Each read port has a fixed DATA_LAT-deep valid/error/data
// pipeline, so a request sampled on edge N is presented during the cycle
// after edge N+DATA_LAT-1. DEPTH need not be a power of two; accesses at or
// above DEPTH are flagged (w_err one cycle after the write, r_err aligned
// with r_dvalid) and never touch the array.
//
// Build option:
//   MEM_FWD_EN  defined     -> a read colliding with an in-range write on the
//                              same edge returns the merged (post-write) word.
//               not defined -> the same collision returns the pre-write word.
//   The array update is identical in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (pipelines only, not array)
//   w_valid    in   write request
//   w_addr     in   [ADDR_WIDTH]           write address
//   w_data     in   [DATA_WIDTH]           write data
//   w_be       in   [BE_WIDTH]             byte enables, bit i -> byte i
//   w_err      out  out-of-range write flag, one cycle after the write
//   r_avalid   in   [NUM_RD]               per-port read request
//   r_addr     in   [NUM_RD*ADDR_WIDTH]    port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   r_dvalid   out  [NUM_RD]               per-port read data valid
//   r_data     out  [NUM_RD*DATA_WIDTH]    port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   r_err      out  [NUM_RD]               per-port out-of-range flag
// -----------------------------------------------------------------------------
module multi_port_latency_memory #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 4,
  parameter  int DEPTH      = 16,
  parameter  int NUM_RD     = 2,
  parameter  int DATA_LAT   = 2,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           w_valid,
  input  logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [BE_WIDTH-1:0]            w_be,
  output logic                           w_err,
  input  logic [NUM_RD-1:0]              r_avalid,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   r_addr,
  output logic [NUM_RD-1:0]              r_dvalid,
  output logic [NUM_RD*DATA_WIDTH-1:0]   r_data,
  output logic [NUM_RD-1:0]              r_err
);

  // Index width into the DEPTH-entry array. Only used once the full address
  // has been range-checked, so dropping upper address bits is safe.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range limit one bit wider than the address so DEPTH == 2**ADDR_WIDTH fits.
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

  logic                          w_in_rng;
  logic                          w_hit;
  logic [DATA_WIDTH-1:0]         mem_q [DEPTH];

  logic [NUM_RD-1:0]             r_in_rng;
  logic [NUM_RD-1:0]             rd_err_d;
  logic [NUM_RD*DATA_WIDTH-1:0]  rd_data_d;

  logic [DATA_LAT-1:0][NUM_RD-1:0]            vld_q;
  logic [DATA_LAT-1:0][NUM_RD-1:0]            err_q;
  logic [DATA_LAT-1:0][NUM_RD*DATA_WIDTH-1:0] dat_q;
  logic                                       w_err_q;

  assign w_in_rng = ({1'b0, w_addr} < DEPTH_X);
  assign w_hit    = w_valid & w_in_rng;

  // Storage array: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (w_hit) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (w_be[b]) begin
          mem_q[w_addr[IDX_W-1:0]][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // First read stage input. Data is forced to zero for idle ports and for
  // out-of-range requests so an idle pipeline always drains to zero.
  always_comb begin
    r_in_rng  = '0;
    rd_err_d  = '0;
    rd_data_d = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      r_in_rng[p] = ({1'b0, r_addr[p*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_X);
      rd_err_d[p] = r_avalid[p] & ~r_in_rng[p];
      if (r_avalid[p] && r_in_rng[p]) begin
        rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[r_addr[p*ADDR_WIDTH +: IDX_W]];
`ifdef MEM_FWD_EN
        // Same-edge collision: overlay the enabled bytes of the incoming write.
        if (w_hit && (w_addr == r_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
          for (int b = 0; b < BE_WIDTH; b++) begin
            if (w_be[b]) begin
              rd_data_d[p*DATA_WIDTH + 8*b +: 8] = w_data[8*b +: 8];
            end
          end
        end
`endif
      end
    end
  end

  // Read pipelines and write error flag. Reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      err_q   <= '0;
      dat_q   <= '0;
      w_err_q <= 1'b0;
    end else begin
      vld_q[0] <= r_avalid;
      err_q[0] <= rd_err_d;
      dat_q[0] <= rd_data_d;
      for (int s = 1; s < DATA_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        err_q[s] <= err_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
      w_err_q <= w_valid & ~w_in_rng;
    end
  end

  assign r_dvalid = vld_q[DATA_LAT-1];
  assign r_err    = err_q[DATA_LAT-1];
  assign r_data   = dat_q[DATA_LAT-1];
  assign w_err    = w_err_q;

endmodule

// File: tb/tb_multi_port_latency_memory.sv
// -----------------------------------------------------------------------------
// tb_multi_port_latency_memory
//
// Bench for multi_port_latency_memory with DEPTH=12, NUM_RD=2, DATA_LAT=2.
// Directed table of per-cycle vectors, a random phase compared against a
// behavioural model (word array + result delay queue), and a hand-written
// mid-stream reset sequence.
// -----------------------------------------------------------------------------
module tb_multi_port_latency_memory;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int NRD   = 2;
  localparam int LAT   = 2;

`ifdef MEM_FWD_EN
  localparam logic [31:0] COLL = 32'h0000_00FF;
`else
  localparam logic [31:0] COLL = 32'h1234_5678;
`endif

  logic            clk;
  logic            rst_n;
  logic            w_valid;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [3:0]      w_be;
  logic            w_err;
  logic [NRD-1:0]  r_avalid;
  logic [NRD*AW-1:0] r_addr;
  logic [NRD-1:0]  r_dvalid;
  logic [NRD*DW-1:0] r_data;
  logic [NRD-1:0]  r_err;

  multi_port_latency_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_RD(NRD), .DATA_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_be(w_be), .w_err(w_err),
    .r_avalid(r_avalid), .r_addr(r_addr),
    .r_dvalid(r_dvalid), .r_data(r_data), .r_err(r_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  err;
    logic [63:0] dat;
  } res_t;

  logic [31:0] mdl_mem [DEPTH];
  res_t        pipe[$];
  logic        exp_werr;

  function automatic res_t zero_res();
    res_t r;
    r.vld = '0;
    r.err = '0;
    r.dat = '0;
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
    logic [31:0] m;
    m = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    return m;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < LAT; i++) pipe.push_back(zero_res());
    exp_werr = 1'b0;
  endtask

  // Applies one sampled edge to the model.
  task automatic model_edge(input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                            input logic [3:0] wbe, input logic [1:0] rav, input logic [7:0] ra);
    res_t        r;
    logic [3:0]  a;
    logic [31:0] w;
    r = zero_res();
    for (int p = 0; p < NRD; p++) begin
      a = ra[p*4 +: 4];
      if (rav[p]) begin
        r.vld[p] = 1'b1;
        if (int'(a) >= DEPTH) begin
          r.err[p] = 1'b1;
        end else begin
          w = mdl_mem[a];
`ifdef MEM_FWD_EN
          if (wv && wa == a) w = merge(w, wd, wbe);
`endif
          r.dat[p*32 +: 32] = w;
        end
      end
    end
    pipe.push_back(r);
    void'(pipe.pop_front());
    exp_werr = wv && (int'(wa) >= DEPTH);
    if (wv && int'(wa) < DEPTH) mdl_mem[wa] = merge(mdl_mem[wa], wd, wbe);
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, advance the model at the rising edge, return
  // 1 time unit after it so the caller samples settled outputs.
  task automatic step(input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] wbe, input logic [1:0] rav, input logic [7:0] ra);
    @(negedge clk);
    w_valid  = wv;
    w_addr   = wa;
    w_data   = wd;
    w_be     = wbe;
    r_avalid = rav;
    r_addr   = ra;
    @(posedge clk);
    model_edge(wv, wa, wd, wbe, rav, ra);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 32'd0, 4'd0, 2'b00, 8'd0);
  endtask

  task automatic check_model(input string tag);
    res_t e;
    e = pipe[0];
    chk({tag, "_dvalid"}, 64'(r_dvalid), 64'(e.vld));
    chk({tag, "_rerr"},   64'(r_err),    64'(e.err));
    chk({tag, "_werr"},   64'(w_err),    64'(exp_werr));
    for (int p = 0; p < NRD; p++)
      if (e.vld[p]) chk($sformatf("%s_data%0d", tag, p), 64'(r_data[p*32 +: 32]), 64'(e.dat[p*32 +: 32]));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        wv;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic [1:0]  rav;
    logic [7:0]  ra;   // {port1, port0}
    logic [1:0]  ev;
    logic [1:0]  ee;
    logic        ew;
    logic [63:0] ed;   // {port1, port0}, compared only where ev is set
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 4'd2,  32'hCAFEF00D, 4'hF, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 64'h0};
    tbl[1]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 64'h0};
    tbl[2]  = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b01, 8'h03, 2'b00, 2'b00, 1'b0, 64'h0};
    tbl[3]  = '{1'b1, 4'd5,  32'h11223344, 4'hF, 2'b00, 8'h00, 2'b01, 2'b00, 1'b0, {32'h0, 32'hDEADBEEF}};
    tbl[4]  = '{1'b1, 4'd5,  32'hAABBCCDD, 4'h5, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 64'h0};
    tbl[5]  = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b11, 8'h55, 2'b00, 2'b00, 1'b0, 64'h0};
    tbl[6]  = '{1'b1, 4'd7,  32'h12345678, 4'hF, 2'b00, 8'h00, 2'b11, 2'b00, 1'b0, {32'h11BB33DD, 32'h11BB33DD}};
    tbl[7]  = '{1'b1, 4'd7,  32'h000000FF, 4'hF, 2'b11, 8'h77, 2'b00, 2'b00, 1'b0, 64'h0};
    tbl[8]  = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b00, 8'h00, 2'b11, 2'b00, 1'b0, {COLL, COLL}};
    tbl[9]  = '{1'b1, 4'd14, 32'hFFFFFFFF, 4'hF, 2'b10, 8'hD0, 2'b00, 2'b00, 1'b1, 64'h0};
    tbl[10] = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b01, 8'h02, 2'b10, 2'b10, 1'b0, 64'h0};
    tbl[11] = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b00, 8'h00, 2'b01, 2'b00, 1'b0, {32'h0, 32'hCAFEF00D}};
    tbl[12] = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 64'h0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic        wv;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic [1:0]  rav;
    logic [3:0]  a0, a1;

    rst_n    = 1'b0;
    w_valid  = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    w_be     = '0;
    r_avalid = '0;
    r_addr   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle: everything held at zero.
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("idle_dvalid", 64'(r_dvalid), 64'h0);
      chk("idle_data",   64'(r_data),   64'h0);
      chk("idle_rerr",   64'(r_err),    64'h0);
      chk("idle_werr",   64'(w_err),    64'h0);
    end

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].wbe, tbl[i].rav, tbl[i].ra);
      chk($sformatf("tbl%0d_dvalid", i), 64'(r_dvalid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_rerr", i),   64'(r_err),    64'(tbl[i].ee));
      chk($sformatf("tbl%0d_werr", i),   64'(w_err),    64'(tbl[i].ew));
      for (int p = 0; p < NRD; p++)
        if (tbl[i].ev[p])
          chk($sformatf("tbl%0d_data%0d", i, p), 64'(r_data[p*32 +: 32]), 64'(tbl[i].ed[p*32 +: 32]));
    end

    // Fill every word so the model knows the full array.
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b1, 4'(a), $urandom, 4'hF, 2'b00, 8'h00);
      check_model("fill");
    end

    // Random traffic, biased towards same-address collisions.
    for (int i = 0; i < 400; i++) begin
      wv  = 1'($urandom_range(0, 1));
      wa  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      wbe = 4'($urandom_range(0, 15));
      rav = 2'($urandom_range(0, 3));
      a0  = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      a1  = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      step(wv, wa, wd, wbe, rav, {a1, a0});
      check_model("rand");
    end
    for (int i = 0; i < LAT; i++) begin
      idle();
      check_model("drain");
    end

    // Stream reads on both ports, reset after the 4th request.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, {4'(i), 4'(i)});
      check_model("stream");
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_dvalid", 64'(r_dvalid), 64'h0);
    chk("rst_data",   64'(r_data),   64'h0);
    chk("rst_rerr",   64'(r_err),    64'h0);
    chk("rst_werr",   64'(w_err),    64'h0);
    model_reset();
    @(negedge clk);
    w_valid  = 1'b0;
    r_avalid = '0;
    @(posedge clk);
    #1;
    chk("rst_hold_dvalid", 64'(r_dvalid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check_model("post_rst_idle");
    end
    step(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, {4'd11, 4'd5});
    check_model("post_rst_req");
    idle();
    check_model("post_rst_lat1");
    idle();
    check_model("post_rst_lat2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_port_latency_memory.md
Name: multi_port_latency_memory

Overview:
Parametrised successor to the single-read-port latency memory. One write port with byte enables and NUM_RD independent read ports, each with its own DATA_LAT-deep valid/data pipeline. Depth need not be a power of two; out-of-range accesses are flagged. Used as the shared storage macro behind pipelined datapaths that need several concurrent read streams with fixed, known latency.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 4, address width in bits.
DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
NUM_RD, 2, number of read ports; >= 1.
DATA_LAT, 2, cycles from read request to data output; >= 1.
BE_WIDTH, DATA_WIDTH/8, derived (localparam); byte-enable width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
w_valid  in  1  write request.
w_addr  in  ADDR_WIDTH  write address.
w_data  in  DATA_WIDTH  write data.
w_be  in  BE_WIDTH  byte enables; bit i gates w_data[8i+7:8i].
w_err  out  1  registered; pulses 1 cycle after a write with w_addr >= DEPTH.
r_avalid  in  NUM_RD  per-port read request.
r_addr  in  NUM_RD*ADDR_WIDTH  per-port read address; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
r_dvalid  out  NUM_RD  per-port read data valid.
r_data  out  NUM_RD*DATA_WIDTH  per-port read data; port p at [p*DATA_WIDTH +: DATA_WIDTH].
r_err  out  NUM_RD  per-port out-of-range flag, aligned with r_dvalid.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valid, error and data stages cleared to 0; r_dvalid = 0, r_data = 0, r_err = 0, w_err = 0. Memory array is not reset (contents undefined until written).
- Reset mid-operation: all in-flight reads are dropped; no r_dvalid is produced for requests sampled before reset. A write sampled on the same edge that reset deasserts is not guaranteed.
- Write: on an edge with w_valid = 1 and w_addr < DEPTH, update only the bytes with w_be = 1. w_be = 0 gives no change. w_addr >= DEPTH: array unchanged, w_err = 1 for exactly the next cycle.
- Read, per port p, fully independent: request sampled at edge N (r_avalid[p] = 1) gives r_dvalid[p] = 1 with r_data[p] valid during the cycle after edge N+DATA_LAT-1, i.e. exactly DATA_LAT cycles later. DATA_LAT = 1 means data follows the request edge directly.
- Back-to-back reads on every cycle are fully pipelined: one result per cycle per port, with no bubbles.
- Data stages capture on every edge; r_data is don't-care when r_dvalid = 0, except after reset, when it is 0.
- Out-of-range read (r_addr >= DEPTH): r_dvalid asserts normally, r_data = 0, r_err = 1 in the same cycle.
- Multiple ports reading the same address on the same cycle return identical data.
- A write at edge N is visible to reads sampled at edge N+1 and later.
- Read and write to the same address at the same edge: see Optional Feature.
- No backpressure: the consumer must accept r_data whenever r_dvalid = 1.

Optional Feature:
Macro MEM_FWD_EN.
- Defined: a read sampled on the same edge as an in-range write to the same address returns the merged word: new bytes where w_be = 1, old bytes elsewhere. This applies to every port independently.
- Not defined: the same collision returns the pre-write contents (read-before-write). The array update itself is identical in both builds.

Test Plan:
- Reset then idle, DATA_LAT=2, NUM_RD=2 -> r_dvalid=2'b00, r_data=0, r_err=0, w_err=0 for 10 cycles.
- Write addr 3 = 32'hDEADBEEF, w_be=4'hF; next cycle port0 reads addr 3 -> exactly 2 cycles later r_dvalid[0]=1, r_data[0]=32'hDEADBEEF; port1 silent.
- Addr 5 = 32'h11223344, then write 32'hAABBCCDD with w_be=4'b0101; read addr 5 -> 32'h11BB33DD.
- Same edge: write addr 7 = 32'h0000_00FF (old 32'h12345678), both ports read addr 7 -> without MEM_FWD_EN both return 32'h12345678; with it both return 32'h000000FF.
- DEPTH=12: read addr 13 on port1 -> r_dvalid[1]=1, r_data[1]=0, r_err[1]=1 after DATA_LAT; write addr 14 -> w_err pulses 1 cycle, no array change.
- Stream reads to addrs 0..7 on both ports every cycle, pull rst_n low after the 4th request -> outputs go 0 immediately; no r_dvalid after reset release until new requests plus DATA_LAT.
